lm_frame_buffer: RTL and testbench



---
 rtl/lm_frame_buffer.sv | 131 +++++++++++++
 tb/tb_lm_frame_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lm_frame_buffer.sv
// Double-buffered 64x64 frame store for an H75 LED-matrix scan driver.
// Writers fill the back bank; the front bank is served one bit plane at a time and swaps at frame start.
module lm_frame_buffer #(
  parameter int BPC        = 4,
  parameter int SLICE_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_enable,
  input  logic [4:0]            next_line,
  input  logic [5:0]            next_column,
  input  logic [SLICE_BITS-1:0] slice,
  input  logic                  wr_en,
  input  logic [5:0]            wr_x,
  input  logic [5:0]            wr_y,
  input  logic [3*BPC-1:0]      wr_rgb,
  input  logic                  swap_req,
  output logic                  swap_pending,
  output logic                  swap_ack,
  output logic                  front_bank,
  output logic                  r1,
  output logic                  g1,
  output logic                  b1,
  output logic                  r2,
  output logic                  g2,
  output logic                  b2
);

  localparam int W  = 3 * BPC;
  localparam int SW = 2 ** SLICE_BITS;
  localparam int AW = 12;

  typedef enum logic {
    IDLE,
    PENDING
  } swap_state_e;

  swap_state_e state_q, state_d;
  logic front_bank_q, front_bank_d;
  logic swap_ack_q;
  logic swap_pending_q, swap_pending_d;
  logic swap_exec;
  logic frame_start;

  logic [W-1:0] mem_upper [0:2**AW-1];
  logic [W-1:0] mem_lower [0:2**AW-1];
  logic [W-1:0] up_word_q, lo_word_q;
  logic [AW-1:0] rd_addr, wr_addr;
  logic rd_bank;

  logic                  rd_valid_q;
  logic [SLICE_BITS-1:0] slice_q;
  logic [2:0]            up_rgb_q, lo_rgb_q;

  // Each component is zero-extended to 2^SLICE_BITS bits so an out-of-range slice reads as 0.
  function automatic logic [2:0] plane_bits(input logic [W-1:0] word,
                                            input logic [SLICE_BITS-1:0] s);
    logic [SW-1:0] r_ext, g_ext, b_ext;
    r_ext = SW'(word[2*BPC +: BPC]);
    g_ext = SW'(word[BPC +: BPC]);
    b_ext = SW'(word[0 +: BPC]);
    return {r_ext[s], g_ext[s], b_ext[s]};
  endfunction

  assign frame_start = clk_enable && (next_line == '0) && (next_column == '0) && (slice == '0);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    swap_exec = 1'b0;
    unique case (state_q)
      IDLE:    if (swap_req) state_d = PENDING;
      PENDING: if (frame_start) begin
        state_d   = IDLE;
        swap_exec = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    front_bank_d = front_bank_q ^ swap_exec;
    // Pending stays up through the ack cycle so it falls one cycle after swap_ack.
    swap_pending_d = (state_d == PENDING) || swap_exec;
  end

  // Reads follow the post-swap front bank; writes hit the pre-swap back bank.
  assign rd_bank = front_bank_d;
  assign rd_addr = {rd_bank, next_line, next_column};
  assign wr_addr = {~front_bank_q, wr_y[4:0], wr_x};

  // NOTE: the frame memories and their read registers carry no reset so they map onto block RAM;
  // contents survive rst_n, and only the valid flag of the read pipeline is cleared.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_y[5]) mem_upper[wr_addr] <= wr_rgb;
    if (wr_en &&  wr_y[5]) mem_lower[wr_addr] <= wr_rgb;
    if (clk_enable) begin
      up_word_q <= mem_upper[rd_addr];
      lo_word_q <= mem_lower[rd_addr];
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      front_bank_q   <= 1'b0;
      swap_ack_q     <= 1'b0;
      swap_pending_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      slice_q        <= '0;
      up_rgb_q       <= '0;
      lo_rgb_q       <= '0;
    end else begin
      state_q        <= state_d;
      front_bank_q   <= front_bank_d;
      swap_ack_q     <= swap_exec;
      swap_pending_q <= swap_pending_d;
      rd_valid_q     <= clk_enable;
      if (clk_enable) slice_q <= slice;
      if (rd_valid_q) begin
        up_rgb_q <= plane_bits(up_word_q, slice_q);
        lo_rgb_q <= plane_bits(lo_word_q, slice_q);
      end
    end
  end

  assign swap_pending  = swap_pending_q;
  assign swap_ack      = swap_ack_q;
  assign front_bank    = front_bank_q;
  assign {r1, g1, b1}  = up_rgb_q;
  assign {r2, g2, b2}  = lo_rgb_q;

endmodule

// File: tb/tb_lm_frame_buffer.sv
// Directed bench for lm_frame_buffer: write, swap, bit-plane reads, swap timing, tear-free writes and reset.
module tb_lm_frame_buffer;

  localparam int BPC        = 4;
  localparam int SLICE_BITS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_enable = 1'b0;
  logic [4:0] next_line = '0;
  logic [5:0] next_column = '0;
  logic [SLICE_BITS-1:0] slice = '0;
  logic wr_en = 1'b0;
  logic [5:0] wr_x = '0;
  logic [5:0] wr_y = '0;
  logic [3*BPC-1:0] wr_rgb = '0;
  logic swap_req = 1'b0;
  logic swap_pending, swap_ack, front_bank;
  logic r1, g1, b1, r2, g2, b2;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;

  lm_frame_buffer #(.BPC(BPC), .SLICE_BITS(SLICE_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .next_line(next_line), .next_column(next_column), .slice(slice),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .swap_req(swap_req), .swap_pending(swap_pending), .swap_ack(swap_ack),
    .front_bank(front_bank),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (swap_ack) ack_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [5:0] x, input logic [5:0] y, input logic [11:0] rgb);
    wr_en = 1'b1; wr_x = x; wr_y = y; wr_rgb = rgb;
    tick();
    wr_en = 1'b0;
  endtask

  // One clk_enable read; up_early is sampled one edge in, up/lo two edges in; three cycles total.
  task automatic read_px(input logic [4:0] line, input logic [5:0] col, input logic [2:0] sl,
                         output logic [2:0] up_early, output logic [2:0] up,
                         output logic [2:0] lo);
    clk_enable = 1'b1; next_line = line; next_column = col; slice = sl;
    tick();
    clk_enable = 1'b0;
    up_early = {r1, g1, b1};
    tick();
    up = {r1, g1, b1};
    lo = {r2, g2, b2};
    tick();
  endtask

  // Drives a frame-start strobe; returns right after the edge that consumed it.
  task automatic frame_start();
    clk_enable = 1'b1; next_line = '0; next_column = '0; slice = '0;
    tick();
    clk_enable = 1'b0;
  endtask

  task automatic request_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  logic [2:0] ue, up, lo;
  logic [2:0] exp_up [4] = '{3'b010, 3'b100, 3'b011, 3'b101};
  logic [2:0] exp_lo [4] = '{3'b110, 3'b110, 3'b010, 3'b010};
  int ack_base;

  initial begin
    #2;
    check("rst_front", front_bank, 0);
    check("rst_pending", swap_pending, 0);
    check("rst_ack", swap_ack, 0);
    check("rst_rgb", {r1, g1, b1, r2, g2, b2}, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("rst_rgb_held", {r1, g1, b1, r2, g2, b2}, 0);

    // Write to back bank 1, swap, read all planes.
    write_px(6'd5, 6'd3,  12'hA5C);
    write_px(6'd5, 6'd35, 12'h3F0);
    request_swap();
    check("pend_rise", swap_pending, 1);
    tick();
    frame_start();
    check("ack1", swap_ack, 1);
    check("front1", front_bank, 1);
    check("pend_in_ack", swap_pending, 1);
    tick();
    check("ack1_drop", swap_ack, 0);
    check("pend_fall", swap_pending, 0);
    tick();
    for (int s = 0; s < 4; s++) begin
      read_px(5'd3, 6'd5, 3'(s), ue, up, lo);
      check($sformatf("up_s%0d", s), up, exp_up[s]);
      check($sformatf("lo_s%0d", s), lo, exp_lo[s]);
      if (s == 1) check("latency_hold", ue, exp_up[0]);
    end

    read_px(5'd3, 6'd5, 3'd5, ue, up, lo);
    check("oor_up", up, 0);
    check("oor_lo", lo, 0);

    // Overwrite back bank 0 without a swap: display must not change.
    write_px(6'd5, 6'd3,  12'hFFF);
    write_px(6'd5, 6'd35, 12'h000);
    write_px(6'd7, 6'd34, 12'hFFF);
    read_px(5'd3, 6'd5, 3'd0, ue, up, lo);
    check("tear_up", up, 3'b010);
    check("tear_lo", lo, 3'b110);
    request_swap();
    tick();
    frame_start();
    check("front0", front_bank, 0);
    tick(); tick();
    for (int s = 0; s < 4; s++) begin
      read_px(5'd3, 6'd5, 3'(s), ue, up, lo);
      check($sformatf("new_up_s%0d", s), up, 3'b111);
      check($sformatf("new_lo_s%0d", s), lo, 3'b000);
    end

    // swap_req held for 100 cycles yields exactly one swap at the next frame start.
    ack_base = ack_cnt;
    swap_req = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    swap_req = 1'b0;
    check("hold_no_ack", ack_cnt - ack_base, 0);
    check("hold_pending", swap_pending, 1);
    frame_start();
    check("hold_ack", swap_ack, 1);
    check("hold_front", front_bank, 1);
    tick();
    check("hold_pend_fall", swap_pending, 0);
    for (int i = 0; i < 5; i++) tick();
    check("hold_one_ack", ack_cnt - ack_base, 1);

    // Request landing on a frame start while IDLE waits for the following frame.
    swap_req = 1'b1;
    frame_start();
    swap_req = 1'b0;
    check("coinc_no_ack", swap_ack, 0);
    check("coinc_front", front_bank, 1);
    check("coinc_pending", swap_pending, 1);
    tick(); tick();
    // Write in the swap cycle lands in the new front bank.
    wr_en = 1'b1; wr_x = 6'd7; wr_y = 6'd2; wr_rgb = 12'h123;
    frame_start();
    wr_en = 1'b0;
    check("coinc_ack", swap_ack, 1);
    check("coinc_front0", front_bank, 0);
    tick(); tick();
    read_px(5'd2, 6'd7, 3'd0, ue, up, lo);
    check("swapwr_up_s0", up, 3'b101);
    check("swapwr_lo_s0", lo, 3'b111);
    read_px(5'd2, 6'd7, 3'd1, ue, up, lo);
    check("swapwr_up_s1", up, 3'b011);

    // Reset while PENDING with nonzero outputs and front bank 1.
    request_swap();
    tick();
    frame_start();
    check("pre_rst_front", front_bank, 1);
    tick(); tick();
    read_px(5'd3, 6'd5, 3'd0, ue, up, lo);
    check("pre_rst_up", up, 3'b010);
    request_swap();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rgb", {r1, g1, b1, r2, g2, b2}, 0);
    check("mid_rst_pend", swap_pending, 0);
    check("mid_rst_front", front_bank, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_rgb", {r1, g1, b1, r2, g2, b2}, 0);
    check("post_rst_pend", swap_pending, 0);
    read_px(5'd3, 6'd5, 3'd0, ue, up, lo);
    check("keep_up", up, 3'b111);
    check("keep_lo", lo, 3'b000);
    read_px(5'd2, 6'd7, 3'd1, ue, up, lo);
    check("keep_up2", up, 3'b011);
    check("keep_lo2", lo, 3'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
